// File: rtl/seg_scan_decoder_if.sv
// Bus bundle for the scanned seven-segment display decoder.
// The master side drives the sniffed segment/select lines and observes
// the recovered frame; the slave side is the decoder itself.
interface seg_scan_decoder_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   dig_sel;
  logic [4*DIGITS-1:0] value_out;
  logic [DIGITS-1:0]   err_out;
  logic                frame_valid;

  modport master (
    output seg_in,
    output dig_sel,
    input  value_out,
    input  err_out,
    input  frame_valid
  );

  modport slave (
    input  seg_in,
    input  dig_sel,
    output value_out,
    output err_out,
    output frame_valid
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers the hex value shown on a multiplexed,
// active-low seven-segment display. Each digit's pattern must be stable
// for STABLE_CYCLES consecutive samples before it is captured; once all
// digits have been captured the assembled frame is published.
module seg_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  seg_scan_decoder_if.slave   bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);

  // Glyph decoder: returns {error, nibble}; unknown patterns give nibble 0.
  function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'h40:   res = 5'h00;
      7'h79:   res = 5'h01;
      7'h24:   res = 5'h02;
      7'h30:   res = 5'h03;
      7'h19:   res = 5'h04;
      7'h12:   res = 5'h05;
      7'h02:   res = 5'h06;
      7'h78:   res = 5'h07;
      7'h00:   res = 5'h08;
      7'h10:   res = 5'h09;
      7'h08:   res = 5'h0A;
      7'h03:   res = 5'h0B;
      7'h46:   res = 5'h0C;
      7'h21:   res = 5'h0D;
      7'h06:   res = 5'h0E;
      7'h0E:   res = 5'h0F;
      default: res = 5'h10;
    endcase
    return res;
  endfunction

  // Exactly one select bit set (zero or several bits are rejected).
  function automatic logic is_onehot(input logic [DIGITS-1:0] v);
    return (v != {DIGITS{1'b0}}) &&
           ((v & (v - {{(DIGITS-1){1'b0}}, 1'b1})) == {DIGITS{1'b0}});
  endfunction

  // Registers
  logic [6:0]          r_seg_q;
  logic [DIGITS-1:0]   r_sel_q;
  logic [CW-1:0]       r_cnt;
  logic [DIGITS-1:0]   r_seen;
  logic [4*DIGITS-1:0] r_shadow_val;
  logic [DIGITS-1:0]   r_shadow_err;
  logic [4*DIGITS-1:0] r_value;
  logic [DIGITS-1:0]   r_err;
  logic                r_frame_valid;

  // Combinational nets
  logic                w_onehot;
  logic                w_changed;
  logic                w_restart;
  logic [CW-1:0]       w_cnt_next;
  logic                w_capture;
  logic [4:0]          w_glyph;
  logic [4*DIGITS-1:0] w_shadow_val_next;
  logic [DIGITS-1:0]   w_shadow_err_next;
  logic [DIGITS-1:0]   w_seen_next;
  logic                w_frame_done;

  // Stability counter: restart on change/bad select, saturate at the dwell length.
  always_comb begin
    w_onehot   = is_onehot(bus.dig_sel);
    w_changed  = ({bus.seg_in, bus.dig_sel} != {r_seg_q, r_sel_q});
    w_restart  = (r_cnt == CNT_ZERO) || w_changed || !w_onehot;
    w_cnt_next = r_cnt;
    w_capture  = 1'b0;
    if (w_restart) begin
      w_cnt_next = w_onehot ? CNT_ONE : CNT_ZERO;
      // A reload to 1 is itself the capture point when one sample suffices.
      w_capture  = w_onehot && (CNT_ONE == CNT_MAX);
    end else if (r_cnt == CNT_MAX) begin
      // Saturated dwell: no further captures until the pattern changes.
      w_cnt_next = CNT_MAX;
      w_capture  = 1'b0;
    end else begin
      w_cnt_next = r_cnt + CNT_ONE;
      w_capture  = (w_cnt_next == CNT_MAX);
    end
  end

  // Shadow merge of the digit being captured and frame-completion detect.
  always_comb begin
    w_glyph           = decode_glyph(bus.seg_in);
    w_shadow_val_next = r_shadow_val;
    w_shadow_err_next = r_shadow_err;
    w_seen_next       = r_seen;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_capture && bus.dig_sel[i]) begin
        w_shadow_val_next[4*i +: 4] = w_glyph[3:0];
        w_shadow_err_next[i]        = w_glyph[4];
        w_seen_next[i]              = 1'b1;
      end else begin
        w_seen_next[i] = r_seen[i];
      end
    end
    w_frame_done = w_capture && (&(r_seen | bus.dig_sel));
  end

  // State and published-frame registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_q       <= 7'h7F;
      r_sel_q       <= {DIGITS{1'b0}};
      r_cnt         <= CNT_ZERO;
      r_seen        <= {DIGITS{1'b0}};
      r_shadow_val  <= {(4*DIGITS){1'b0}};
      r_shadow_err  <= {DIGITS{1'b0}};
      r_value       <= {(4*DIGITS){1'b0}};
      r_err         <= {DIGITS{1'b0}};
      r_frame_valid <= 1'b0;
    end else begin
      r_seg_q       <= bus.seg_in;
      r_sel_q       <= bus.dig_sel;
      r_cnt         <= w_cnt_next;
      r_shadow_val  <= w_shadow_val_next;
      r_shadow_err  <= w_shadow_err_next;
      r_frame_valid <= w_frame_done;
      if (w_frame_done) begin
        r_value <= w_shadow_val_next;
        r_err   <= w_shadow_err_next;
        r_seen  <= {DIGITS{1'b0}};
      end else begin
        r_seen  <= w_seen_next;
      end
    end
  end

  assign bus.value_out   = r_value;
  assign bus.err_out     = r_err;
  assign bus.frame_valid = r_frame_valid;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder (DIGITS=4, STABLE_CYCLES=4).
module tb_seg_scan_decoder;
  localparam int DIGITS = 4;
  localparam int SC     = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int pulses = 0;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state
  logic [6:0]  m_prev_seg;
  logic [3:0]  m_prev_sel;
  int          m_run;
  logic [3:0]  m_seen;
  logic [15:0] m_shadow_val;
  logic [3:0]  m_shadow_err;
  logic [15:0] exp_val;
  logic [3:0]  exp_err;
  logic        exp_fv;

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int n = 0; n < 16; n++) begin
      if (glyph_tab[n] == p) return {1'b0, 4'(n)};
    end
    return 5'h10;
  endfunction

  // One clock: apply inputs, advance the model at the edge, sample #1 later.
  task automatic step(input logic r, input logic [6:0] s, input logic [3:0] d);
    int idx;
    logic [4:0] dec;
    rst = r;
    bus.seg_in = s;
    bus.dig_sel = d;
    @(posedge clk);
    if (r) begin
      m_prev_seg = 7'h7F; m_prev_sel = 4'h0; m_run = 0; m_seen = 4'h0;
      m_shadow_val = 16'h0; m_shadow_err = 4'h0;
      exp_val = 16'h0; exp_err = 4'h0; exp_fv = 1'b0;
    end else begin
      exp_fv = 1'b0;
      if ($countones(d) == 1 && s == m_prev_seg && d == m_prev_sel && m_run > 0)
        m_run++;
      else
        m_run = ($countones(d) == 1) ? 1 : 0;
      if (m_run == SC) begin
        idx = 0;
        for (int k = 0; k < DIGITS; k++) if (d[k]) idx = k;
        dec = ref_decode(s);
        m_shadow_val[4*idx +: 4] = dec[3:0];
        m_shadow_err[idx] = dec[4];
        m_seen[idx] = 1'b1;
        if (m_seen == 4'hF) begin
          exp_val = m_shadow_val; exp_err = m_shadow_err; exp_fv = 1'b1; m_seen = 4'h0;
        end
      end
      m_prev_seg = s; m_prev_sel = d;
    end
    #1;
    if (bus.frame_valid === 1'b1) pulses++;
  endtask

  task automatic dwell(input logic [6:0] s, input logic [3:0] d, input int n);
    for (int c = 0; c < n; c++) step(1'b0, s, d);
  endtask

  task automatic do_reset();
    step(1'b1, 7'h7F, 4'h0);
    step(1'b1, 7'h7F, 4'h0);
    pulses = 0;
  endtask

  task automatic test_reset();
    step(1'b1, 7'($urandom), 4'($urandom));
    step(1'b1, 7'($urandom), 4'($urandom));
    total++; if (bus.value_out !== 16'h0) begin bad++; $display("FAIL reset_value got=%h exp=0000", bus.value_out); end
    total++; if (bus.err_out !== 4'h0) begin bad++; $display("FAIL reset_err got=%b exp=0000", bus.err_out); end
    total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b exp=0", bus.frame_valid); end
    pulses = 0;
    dwell(7'h40, 4'h1, SC);
    total++; if (pulses !== 0) begin bad++; $display("FAIL reset_no_pulse got=%0d exp=0", pulses); end
  endtask

  task automatic test_full_frame();
    do_reset();
    dwell(7'h79, 4'h1, 4); dwell(7'h24, 4'h2, 4); dwell(7'h30, 4'h4, 4); dwell(7'h19, 4'h8, 3);
    total++; if (pulses !== 0) begin bad++; $display("FAIL full_early got=%0d exp=0", pulses); end
    step(1'b0, 7'h19, 4'h8);
    total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL full_fv got=%b exp=1", bus.frame_valid); end
    total++; if (bus.value_out !== 16'h4321) begin bad++; $display("FAIL full_value got=%h exp=4321", bus.value_out); end
    total++; if (bus.err_out !== 4'h0) begin bad++; $display("FAIL full_err got=%b exp=0000", bus.err_out); end
    step(1'b0, 7'h7F, 4'h0);
    total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL full_fv_drop got=%b exp=0", bus.frame_valid); end
    total++; if (bus.value_out !== 16'h4321) begin bad++; $display("FAIL full_hold got=%h exp=4321", bus.value_out); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL full_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_glitch();
    do_reset();
    dwell(7'h79, 4'h1, 4); dwell(7'h24, 4'h2, 4); dwell(7'h30, 4'h4, 4);
    dwell(7'h19, 4'h8, 3); dwell(7'h79, 4'h1, 4);
    total++; if (pulses !== 0) begin bad++; $display("FAIL glitch_no_pulse got=%0d exp=0", pulses); end
    dwell(7'h19, 4'h8, 4);
    total++; if (pulses !== 1) begin bad++; $display("FAIL glitch_pulses got=%0d exp=1", pulses); end
    total++; if (bus.value_out !== 16'h4321) begin bad++; $display("FAIL glitch_value got=%h exp=4321", bus.value_out); end
  endtask

  task automatic test_invalid_glyph();
    do_reset();
    dwell(7'h0E, 4'h1, 4); dwell(7'h24, 4'h2, 4); dwell(7'h7F, 4'h4, 4); dwell(7'h19, 4'h8, 4);
    total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL inv_fv got=%b exp=1", bus.frame_valid); end
    total++; if (bus.err_out !== 4'b0100) begin bad++; $display("FAIL inv_err got=%b exp=0100", bus.err_out); end
    total++; if (bus.value_out !== 16'h402F) begin bad++; $display("FAIL inv_value got=%h exp=402f", bus.value_out); end
  endtask

  task automatic test_dwell_bad_select();
    do_reset();
    dwell(7'h24, 4'h2, 20); dwell(7'h79, 4'h1, 4); dwell(7'h30, 4'h4, 4);
    total++; if (pulses !== 0) begin bad++; $display("FAIL dwell_early got=%0d exp=0", pulses); end
    dwell(7'h19, 4'h8, 4);
    total++; if (pulses !== 1) begin bad++; $display("FAIL dwell_pulses got=%0d exp=1", pulses); end
    total++; if (bus.value_out !== 16'h4321) begin bad++; $display("FAIL dwell_value got=%h exp=4321", bus.value_out); end
    pulses = 0;
    dwell(7'h40, 4'h1, 4); dwell(7'h02, 4'h2, 4);
    dwell(7'h78, 4'b0011, 10); dwell(7'h7F, 4'b0000, 10);
    total++; if (pulses !== 0 || bus.value_out !== 16'h4321) begin
      bad++; $display("FAIL badsel_hold pulses=%0d value=%h exp pulses=0 value=4321", pulses, bus.value_out);
    end
    dwell(7'h78, 4'h4, 4); dwell(7'h00, 4'h8, 4);
    total++; if (pulses !== 1 || bus.value_out !== 16'h8760) begin
      bad++; $display("FAIL badsel_seen pulses=%0d value=%h exp pulses=1 value=8760", pulses, bus.value_out);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    dwell(7'h79, 4'h1, 4); dwell(7'h24, 4'h2, 4);
    do_reset();
    total++; if (bus.value_out !== 16'h0) begin bad++; $display("FAIL midrst_value got=%h exp=0000", bus.value_out); end
    dwell(7'h30, 4'h4, 4); dwell(7'h19, 4'h8, 4);
    total++; if (pulses !== 0) begin bad++; $display("FAIL midrst_no_pulse got=%0d exp=0", pulses); end
    dwell(7'h78, 4'h4, 4); dwell(7'h00, 4'h8, 4); dwell(7'h40, 4'h1, 4); dwell(7'h02, 4'h2, 4);
    total++; if (pulses !== 1 || bus.value_out !== 16'h8760 || bus.err_out !== 4'h0) begin
      bad++; $display("FAIL midrst_frame pulses=%0d value=%h err=%b exp pulses=1 value=8760 err=0000",
                      pulses, bus.value_out, bus.err_out);
    end
  endtask

  task automatic test_random();
    logic [6:0] s;
    logic [3:0] d;
    int n;
    do_reset();
    for (int seg_i = 0; seg_i < 120; seg_i++) begin
      d = ($urandom % 5 == 0) ? 4'($urandom) : (4'h1 << ($urandom % 4));
      s = ($urandom % 7 == 0) ? 7'($urandom) : glyph_tab[$urandom % 16];
      n = $urandom_range(1, 6);
      for (int c = 0; c < n; c++) begin
        step(1'b0, s, d);
        total++;
        if (bus.frame_valid !== exp_fv || bus.value_out !== exp_val || bus.err_out !== exp_err) begin
          bad++;
          $display("FAIL random fv=%b value=%h err=%b exp fv=%b value=%h err=%b",
                   bus.frame_valid, bus.value_out, bus.err_out, exp_fv, exp_val, exp_err);
        end
      end
    end
  endtask

  initial begin
    bus.seg_in = 7'h7F;
    bus.dig_sel = 4'h0;
    test_reset();
    test_full_frame();
    test_glitch();
    test_invalid_glyph();
    test_dwell_bad_select();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
